shared_reg_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit synchronous register among N_REQ requesters.
- The register has true and complementary outputs (Q/Q_n) and the same reset semantics as the team's D flip-flop cells.
- The block grants one requester at a time, commits that requester's data into the register, and counts completed writes.
- It sits between multiple write sources and a single shared status/control register.

---
 rtl/shared_reg_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 38 +++
 rtl/shared_reg_arbiter.sv | 111 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared types for the round-robin shared-register arbiter:
// FSM state encoding, index width helper and the requester index type.
package shared_reg_arb_pkg;

    // Largest supported requester count; idx_t is sized for it.
    localparam int MAX_REQ = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int IDX_W = clog2(MAX_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches req starting at ptr,
// wrapping; outputs valid, winner index and one-hot winner mask.
module rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  idx_t             ptr,
    output logic             valid,
    output idx_t             idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] rot;

    always_comb begin
        int sel;
        int sum;
        // Rotate so that bit 0 is the requester at ptr.
        rot   = N_REQ'({req, req} >> ptr);
        valid = 1'b0;
        sel   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sel   = k;
            end
        end
        sum = int'(ptr) + sel;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        idx    = idx_t'(sum);
        onehot = valid ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register (Q/Q_n) among
// N_REQ requesters. Ports: CLK, RST (sync, active-high), REQ, WDATA,
// GNT (one-hot, registered), Q, Q_n, BUSY, WR_STB, WR_CNT.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] WDATA,
    output logic [N_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       Q_n,
    output logic                   BUSY,
    output logic                   WR_STB,
    output logic [CNT_W-1:0]       WR_CNT
);

    state_t           state, state_nxt;
    idx_t             ptr, ptr_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [WIDTH-1:0] q_nxt, qn_nxt, wsel;
    logic             stb_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pick_valid;
    idx_t             pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic             commit;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (REQ),
        .ptr    (ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    // GNT is the latched one-hot winner, so it doubles as the data mux select.
    always_comb begin
        wsel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (GNT[i]) begin
                wsel = WDATA[i*WIDTH +: WIDTH];
            end
        end
    end

    // Winner still requesting at the end of GRANT means the write commits.
    assign commit = |(REQ & GNT);
    assign BUSY   = (state == ST_GRANT);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = GNT;
        q_nxt     = Q;
        qn_nxt    = Q_n;
        stb_nxt   = 1'b0;
        cnt_nxt   = WR_CNT;
        unique case (1'b1)
            (state == ST_IDLE): begin
                gnt_nxt = '0;
                if (pick_valid) begin
                    gnt_nxt   = pick_oh;
                    ptr_nxt   = (pick_idx == idx_t'(N_REQ - 1)) ?
                                '0 : pick_idx + 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            (state == ST_GRANT): begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
                if (commit) begin
                    q_nxt   = wsel;
                    qn_nxt  = ~wsel;
                    stb_nxt = 1'b1;
                    cnt_nxt = WR_CNT + 1'b1;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            GNT    <= '0;
            Q      <= '0;
            Q_n    <= '1;
            WR_STB <= 1'b0;
            WR_CNT <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            GNT    <= gnt_nxt;
            Q      <= q_nxt;
            Q_n    <= qn_nxt;
            WR_STB <= stb_nxt;
            WR_CNT <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed testbench for shared_reg_arbiter: reset, single write,
// fairness, pointer wrap, abort, reset mid-grant and counter wrap.
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q, q_n;
    logic        busy, wr_stb;
    logic [7:0]  wr_cnt;

    logic        rst2;
    logic [3:0]  req2;
    logic [31:0] wdata2;
    logic [3:0]  gnt2;
    logic [7:0]  q2, q2_n;
    logic        busy2, stb2;
    logic [1:0]  cnt2;

    int n_cmp;
    int n_bad;

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(8)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .WDATA(wdata),
        .GNT(gnt), .Q(q), .Q_n(q_n), .BUSY(busy),
        .WR_STB(wr_stb), .WR_CNT(wr_cnt)
    );

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(2)) dut2 (
        .CLK(clk), .RST(rst2), .REQ(req2), .WDATA(wdata2),
        .GNT(gnt2), .Q(q2), .Q_n(q2_n), .BUSY(busy2),
        .WR_STB(stb2), .WR_CNT(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp += 6;
        if (q !== 8'h00) begin n_bad++; $display("FAIL rst_q got %h exp 00", q); end
        if (q_n !== 8'hFF) begin n_bad++; $display("FAIL rst_qn got %h exp ff", q_n); end
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got %b exp 0000", gnt); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL rst_stb got %b exp 0", wr_stb); end
        if (wr_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_cnt got %0d exp 0", wr_cnt); end
    endtask

    task automatic test_single_write();
        req   = 4'b0001;
        wdata = 32'h0000_00A5;
        tick();
        n_cmp += 3;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL sw_gnt got %b exp 0001", gnt); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL sw_busy got %b exp 1", busy); end
        if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL sw_stb0 got %b exp 0", wr_stb); end
        tick();
        req = 4'b0000;
        n_cmp += 5;
        if (q !== 8'hA5) begin n_bad++; $display("FAIL sw_q got %h exp a5", q); end
        if (q_n !== 8'h5A) begin n_bad++; $display("FAIL sw_qn got %h exp 5a", q_n); end
        if (wr_stb !== 1'b1) begin n_bad++; $display("FAIL sw_stb got %b exp 1", wr_stb); end
        if (wr_cnt !== 8'd1) begin n_bad++; $display("FAIL sw_cnt got %0d exp 1", wr_cnt); end
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL sw_gnt_off got %b exp 0000", gnt); end
        tick();
        n_cmp += 1;
        if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL sw_stb_pulse got %b exp 0", wr_stb); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] eq;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req   = 4'b1111;
        wdata = 32'h04_03_02_01;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            eq = 8'((k % 4) + 1);
            tick();
            n_cmp += 1;
            if (gnt !== eg) begin n_bad++; $display("FAIL rr_gnt%0d got %b exp %b", k, gnt, eg); end
            tick();
            n_cmp += 3;
            if (q !== eq) begin n_bad++; $display("FAIL rr_q%0d got %h exp %h", k, q, eq); end
            if (q_n !== ~eq) begin n_bad++; $display("FAIL rr_qn%0d got %h exp %h", k, q_n, ~eq); end
            if (wr_cnt !== 8'(k + 1)) begin n_bad++; $display("FAIL rr_cnt%0d got %0d exp %0d", k, wr_cnt, k + 1); end
        end
        req = 4'b0000;
    endtask

    task automatic test_ptr_wrap();
        wdata = 32'h44_33_22_11;
        req   = 4'b0100;
        tick();
        n_cmp += 1;
        if (gnt !== 4'b0100) begin n_bad++; $display("FAIL pw_gnt2 got %b exp 0100", gnt); end
        tick();
        req = 4'b1001;
        tick();
        n_cmp += 1;
        if (gnt !== 4'b1000) begin n_bad++; $display("FAIL pw_gnt3 got %b exp 1000", gnt); end
        tick();
        n_cmp += 1;
        if (q !== 8'h44) begin n_bad++; $display("FAIL pw_q3 got %h exp 44", q); end
        tick();
        n_cmp += 1;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL pw_gnt0 got %b exp 0001", gnt); end
        tick();
        req = 4'b0000;
        n_cmp += 2;
        if (q !== 8'h11) begin n_bad++; $display("FAIL pw_q0 got %h exp 11", q); end
        if (wr_cnt !== 8'd8) begin n_bad++; $display("FAIL pw_cnt got %0d exp 8", wr_cnt); end
    endtask

    task automatic test_withdraw();
        req   = 4'b0010;
        wdata = 32'h00_00_3C_00;
        tick();
        n_cmp += 1;
        if (gnt !== 4'b0010) begin n_bad++; $display("FAIL wd_gnt got %b exp 0010", gnt); end
        req = 4'b0000;
        tick();
        n_cmp += 5;
        if (q !== 8'h11) begin n_bad++; $display("FAIL wd_q got %h exp 11", q); end
        if (q_n !== 8'hEE) begin n_bad++; $display("FAIL wd_qn got %h exp ee", q_n); end
        if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL wd_stb got %b exp 0", wr_stb); end
        if (wr_cnt !== 8'd8) begin n_bad++; $display("FAIL wd_cnt got %0d exp 8", wr_cnt); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_busy got %b exp 0", busy); end
        req = 4'b0111;
        tick();
        n_cmp += 1;
        if (gnt !== 4'b0100) begin n_bad++; $display("FAIL wd_next got %b exp 0100", gnt); end
        tick();
        req = 4'b0000;
        n_cmp += 1;
        if (wr_cnt !== 8'd9) begin n_bad++; $display("FAIL wd_cnt2 got %0d exp 9", wr_cnt); end
    endtask

    task automatic test_reset_mid_grant();
        req   = 4'b0001;
        wdata = 32'h0000_00FF;
        tick();
        n_cmp += 1;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy got %b exp 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        n_cmp += 6;
        if (q !== 8'h00) begin n_bad++; $display("FAIL rm_q got %h exp 00", q); end
        if (q_n !== 8'hFF) begin n_bad++; $display("FAIL rm_qn got %h exp ff", q_n); end
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rm_gnt got %b exp 0000", gnt); end
        if (wr_cnt !== 8'd0) begin n_bad++; $display("FAIL rm_cnt got %0d exp 0", wr_cnt); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_state got %b exp 0", busy); end
        if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL rm_stb got %b exp 0", wr_stb); end
    endtask

    task automatic test_counter_wrap();
        int pulses;
        pulses = 0;
        rst2   = 1'b1;
        tick();
        rst2   = 1'b0;
        req2   = 4'b0001;
        wdata2 = 32'h0000_005C;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (stb2) pulses++;
            tick();
            if (stb2) pulses++;
            n_cmp += 1;
            if (cnt2 !== 2'((k + 1) % 4)) begin n_bad++; $display("FAIL cw_cnt%0d got %0d exp %0d", k, cnt2, (k + 1) % 4); end
        end
        req2 = 4'b0000;
        tick();
        if (stb2) pulses++;
        n_cmp += 2;
        if (pulses != 5) begin n_bad++; $display("FAIL cw_pulses got %0d exp 5", pulses); end
        if (q2 !== 8'h5C) begin n_bad++; $display("FAIL cw_q got %h exp 5c", q2); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        req    = '0;
        wdata  = '0;
        rst2   = 1'b1;
        req2   = '0;
        wdata2 = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_ptr_wrap();
        test_withdraw();
        test_reset_mid_grant();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
